// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES decryption key path.
package aes_dec_pkg;

    localparam int unsigned PTR_W  = 4;
    localparam int unsigned NR_128 = 10;
    localparam int unsigned NR_192 = 12;
    localparam int unsigned NR_256 = 14;

    typedef enum logic [1:0] {
        KLEN128  = 2'b00,
        KLEN192  = 2'b01,
        KLEN256  = 2'b10,
        KLEN_INV = 2'b11
    } klen_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LOAD  = 2'b01,
        SERVE = 2'b10
    } seq_state_t;

    // Last round index for a key length; the invalid code never gets latched.
    function automatic logic [PTR_W-1:0] klen_to_nr(input klen_t klen);
        logic [PTR_W-1:0] nr;
        case (klen)
            KLEN192: nr = PTR_W'(NR_192);
            KLEN256: nr = PTR_W'(NR_256);
            default: nr = PTR_W'(NR_128);
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/rk_regfile.sv
// Round-key storage: one synchronous write port, one asynchronous read port.
module rk_regfile #(
    parameter int unsigned KEY_W = 128,
    parameter int unsigned DEPTH = 15,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [KEY_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [KEY_W-1:0] o_rdata
);

    logic [KEY_W-1:0] r_mem [DEPTH];

    // Key slots carry no reset; they are always rewritten before being served.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dec_rkey_sequencer.sv
// Loads a forward key schedule and serves it in reverse order, block after block.
module dec_rkey_sequencer
    import aes_dec_pkg::*;
#(
    parameter int unsigned KEY_W  = 128,
    parameter int unsigned MAX_RK = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [1:0]       klen_in,
    input  logic             key_flush,
    input  logic [KEY_W-1:0] rk_in,
    input  logic             rk_in_vld,
    output logic             rk_in_rdy,
    output logic [KEY_W-1:0] rkey,
    output logic             rkey_vld,
    input  logic             next_rkey,
    output logic [1:0]       klen_sel,
    output logic             busy,
    output logic             cfg_err
);

    seq_state_t       r_state,     w_state_nxt;
    logic [PTR_W-1:0] r_wptr,      w_wptr_nxt;
    logic [PTR_W-1:0] r_rptr,      w_rptr_nxt;
    klen_t            r_klen,      w_klen_nxt;
    logic             r_cfg_err,   w_cfg_err_nxt;
    logic             r_pend_load, w_pend_load_nxt;
    logic             r_pend_flush, w_pend_flush_nxt;
    klen_t            r_pend_klen, w_pend_klen_nxt;

    logic [PTR_W-1:0] w_nr;
    logic             w_busy;
    logic             w_we;
    logic [KEY_W-1:0] w_rdata;
    logic             w_act;
    logic             w_act_flush;
    klen_t            w_act_klen;

    assign w_nr   = klen_to_nr(r_klen);
    assign w_busy = (r_state == SERVE) && (r_rptr != w_nr);
    // A load/flush request in the same cycle pre-empts the write beat.
    assign w_we   = (r_state == LOAD) && rk_in_vld && !key_load && !key_flush;

    rk_regfile #(
        .KEY_W (KEY_W),
        .DEPTH (MAX_RK),
        .AW    (PTR_W)
    ) u_rk_regfile (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (rk_in),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= EMPTY;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_klen       <= KLEN128;
            r_cfg_err    <= 1'b0;
            r_pend_load  <= 1'b0;
            r_pend_flush <= 1'b0;
            r_pend_klen  <= KLEN128;
        end else begin
            r_state      <= w_state_nxt;
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_klen       <= w_klen_nxt;
            r_cfg_err    <= w_cfg_err_nxt;
            r_pend_load  <= w_pend_load_nxt;
            r_pend_flush <= w_pend_flush_nxt;
            r_pend_klen  <= w_pend_klen_nxt;
        end
    end

    // Next-state: loading, serving, and load/flush requests deferred to block boundaries.
    always_comb begin
        w_state_nxt      = r_state;
        w_wptr_nxt       = r_wptr;
        w_rptr_nxt       = r_rptr;
        w_klen_nxt       = r_klen;
        w_cfg_err_nxt    = r_cfg_err;
        w_pend_load_nxt  = r_pend_load;
        w_pend_flush_nxt = r_pend_flush;
        w_pend_klen_nxt  = r_pend_klen;
        w_act            = 1'b0;
        w_act_flush      = 1'b0;
        w_act_klen       = klen_t'(klen_in);

        unique case (r_state)
            EMPTY: begin
                // Nothing to flush here; a flush in the same cycle still suppresses the load.
                w_act = key_load && !key_flush;
            end
            LOAD: begin
                if (key_load || key_flush) begin
                    w_act       = 1'b1;
                    w_act_flush = key_flush;
                end else if (rk_in_vld) begin
                    w_wptr_nxt = PTR_W'(r_wptr + 1'b1);
                    if (r_wptr == w_nr) begin
                        w_state_nxt = SERVE;
                        w_rptr_nxt  = w_nr;
                    end
                end
            end
            SERVE: begin
                if ((key_load || key_flush) && !w_busy && !next_rkey) begin
                    w_act       = 1'b1;
                    w_act_flush = key_flush;
                end else if ((r_pend_load || r_pend_flush) && (r_rptr == w_nr) && !next_rkey) begin
                    w_act       = 1'b1;
                    w_act_flush = r_pend_flush;
                    w_act_klen  = r_pend_klen;
                end else begin
                    if (next_rkey) begin
                        w_rptr_nxt = (r_rptr == '0) ? w_nr : PTR_W'(r_rptr - 1'b1);
                    end
                    if (key_flush) begin
                        w_pend_flush_nxt = 1'b1;
                        w_pend_load_nxt  = 1'b0;
                    end else if (key_load) begin
                        w_pend_load_nxt  = 1'b1;
                        w_pend_flush_nxt = 1'b0;
                        w_pend_klen_nxt  = klen_t'(klen_in);
                    end
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase

        // Execute an accepted request; an invalid length drops the schedule.
        if (w_act) begin
            w_pend_load_nxt  = 1'b0;
            w_pend_flush_nxt = 1'b0;
            if (w_act_flush) begin
                w_state_nxt = EMPTY;
            end else if (w_act_klen == KLEN_INV) begin
                w_cfg_err_nxt = 1'b1;
                w_state_nxt   = EMPTY;
            end else begin
                w_klen_nxt    = w_act_klen;
                w_wptr_nxt    = '0;
                w_cfg_err_nxt = 1'b0;
                w_state_nxt   = LOAD;
            end
        end
    end

    // Output decode from the state registers.
    always_comb begin
        rk_in_rdy = (r_state == LOAD);
        rkey_vld  = (r_state == SERVE);
        rkey      = (r_state == SERVE) ? w_rdata : '0;
        klen_sel  = r_klen;
        busy      = w_busy;
        cfg_err   = r_cfg_err;
    end

endmodule

// File: tb/tb_dec_rkey_sequencer.sv
// Bench for dec_rkey_sequencer: directed scenarios plus random traffic against a schedule model.
module tb_dec_rkey_sequencer;

    localparam int unsigned KW = 128;

    logic          clk;
    logic          rst;
    logic          key_load;
    logic [1:0]    klen_in;
    logic          key_flush;
    logic [KW-1:0] rk_in;
    logic          rk_in_vld;
    logic          rk_in_rdy;
    logic [KW-1:0] rkey;
    logic          rkey_vld;
    logic          next_rkey;
    logic [1:0]    klen_sel;
    logic          busy;
    logic          cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    dec_rkey_sequencer #(.KEY_W(KW), .MAX_RK(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .klen_in   (klen_in),
        .key_flush (key_flush),
        .rk_in     (rk_in),
        .rk_in_vld (rk_in_vld),
        .rk_in_rdy (rk_in_rdy),
        .rkey      (rkey),
        .rkey_vld  (rkey_vld),
        .next_rkey (next_rkey),
        .klen_sel  (klen_sel),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: what the host has loaded and how far the engine is through the current block.
    int            m_mode;      // 0 no schedule, 1 collecting keys, 2 serving
    logic [KW-1:0] m_keys [16];
    int            m_nr;
    int            m_nwr;       // keys collected so far
    int            m_used;      // keys consumed in the current block
    logic [1:0]    m_klen;
    bit            m_err;
    int            m_pend;      // 0 none, 1 load, 2 flush
    logic [1:0]    m_pklen;

    function automatic int nr_of(input logic [1:0] k);
        return (k == 2'd1) ? 12 : (k == 2'd2) ? 14 : 10;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_nr = 10; m_nwr = 0; m_used = 0;
        m_klen = 2'd0; m_err = 1'b0; m_pend = 0; m_pklen = 2'd0;
    endtask

    task automatic model_step();
        bit         act;
        bit         af;
        bit         boundary;
        logic [1:0] ak;
        act = 1'b0; af = 1'b0; ak = klen_in;
        if (m_mode == 0) begin
            act = key_load && !key_flush;
        end else if (m_mode == 1) begin
            if (key_load || key_flush) begin
                act = 1'b1; af = key_flush;
            end else if (rk_in_vld) begin
                m_keys[m_nwr] = rk_in;
                m_nwr++;
                if (m_nwr == m_nr + 1) begin
                    m_mode = 2; m_used = 0;
                end
            end
        end else begin
            boundary = (m_used == 0) && !next_rkey;
            if ((key_load || key_flush) && boundary) begin
                act = 1'b1; af = key_flush;
            end else if (m_pend != 0 && boundary) begin
                act = 1'b1; af = (m_pend == 2); ak = m_pklen;
            end else begin
                if (next_rkey) m_used = (m_used == m_nr) ? 0 : m_used + 1;
                if (key_flush) m_pend = 2;
                else if (key_load) begin m_pend = 1; m_pklen = klen_in; end
            end
        end
        if (act) begin
            m_pend = 0;
            if (af) m_mode = 0;
            else if (ak == 2'd3) begin m_err = 1'b1; m_mode = 0; end
            else begin
                m_klen = ak; m_nr = nr_of(ak); m_nwr = 0; m_err = 1'b0; m_mode = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [KW-1:0] exp_key;
        exp_key = (m_mode == 2) ? m_keys[m_nr - m_used] : '0;
        check_eq({tag, "_rdy"},   KW'(rk_in_rdy), KW'(m_mode == 1));
        check_eq({tag, "_vld"},   KW'(rkey_vld),  KW'(m_mode == 2));
        check_eq({tag, "_rkey"},  rkey,           exp_key);
        check_eq({tag, "_klen"},  KW'(klen_sel),  KW'(m_klen));
        check_eq({tag, "_busy"},  KW'(busy),      KW'((m_mode == 2) && (m_used != 0)));
        check_eq({tag, "_err"},   KW'(cfg_err),   KW'(m_err));
    endtask

    // One clock: check at the falling edge, advance the model on the rising edge.
    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        key_load = 1'b0; key_flush = 1'b0; klen_in = 2'd0;
        rk_in = '0; rk_in_vld = 1'b0; next_rkey = 1'b0;
    endtask

    task automatic pulse_load(input logic [1:0] k);
        key_load = 1'b1; klen_in = k;
        step("load");
        key_load = 1'b0;
    endtask

    task automatic pulse_flush();
        key_flush = 1'b1;
        step("flush");
        key_flush = 1'b0;
    endtask

    task automatic load_keys(input int n, input bit gaps, output int writes);
        int idx;
        int c;
        idx = 0; c = 0; writes = 0;
        while (idx < n && c < 200) begin
            rk_in_vld = gaps ? (c % 2 == 0) : 1'b1;
            rk_in = {$urandom, $urandom, $urandom, $urandom};
            if (rk_in_vld && m_mode == 1) writes++;
            step("ld");
            if (rk_in_vld) idx++;
            c++;
        end
        rk_in_vld = 1'b0;
    endtask

    logic [KW-1:0] kexp;
    int            nw;

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        step("rst");
        step("rst");
        rst = 1'b1;
        step("idle");

        // AES-128, pattern keys, no gaps
        pulse_load(2'd0);
        for (int i = 0; i <= 10; i++) begin
            rk_in_vld = 1'b1;
            rk_in = {16{8'(i)}};
            step("t1ld");
        end
        rk_in_vld = 1'b0;
        check_eq("t1_rdy_drop", KW'(rk_in_rdy), KW'(0));
        check_eq("t1_vld", KW'(rkey_vld), KW'(1));
        check_eq("t1_klen", KW'(klen_sel), KW'(0));
        for (int i = 10; i >= 0; i--) begin
            kexp = {16{8'(i)}};
            check_eq("t1_seq", rkey, kexp);
            next_rkey = 1'b1;
            step("t1sv");
        end
        next_rkey = 1'b0;
        kexp = {16{8'd10}};
        check_eq("t1_wrap", rkey, kexp);
        check_eq("t1_busy", KW'(busy), KW'(0));

        // AES-256 with gaps, then continuous consumption across two blocks
        pulse_flush();
        pulse_load(2'd2);
        load_keys(15, 1'b1, nw);
        check_eq("t2_writes", KW'(nw), KW'(15));
        check_eq("t2_klen", KW'(klen_sel), KW'(2));
        next_rkey = 1'b1;
        for (int i = 0; i < 30; i++) begin
            check_eq("t2_seq", rkey, m_keys[14 - (i % 15)]);
            check_eq("t2_nobubble", KW'(rkey_vld), KW'(1));
            step("t2sv");
        end
        next_rkey = 1'b0;

        // Invalid key length from EMPTY
        pulse_flush();
        pulse_load(2'd3);
        check_eq("t3_err", KW'(cfg_err), KW'(1));
        check_eq("t3_rdy", KW'(rk_in_rdy), KW'(0));
        check_eq("t3_vld", KW'(rkey_vld), KW'(0));
        pulse_load(2'd1);
        check_eq("t3_err_clr", KW'(cfg_err), KW'(0));

        // AES-192: flush mid-block is deferred to the boundary
        load_keys(13, 1'b0, nw);
        next_rkey = 1'b1;
        for (int i = 0; i < 5; i++) step("t4a");
        next_rkey = 1'b0;
        key_flush = 1'b1;
        step("t4f");
        key_flush = 1'b0;
        check_eq("t4_still_vld", KW'(rkey_vld), KW'(1));
        next_rkey = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            check_eq("t4_seq", rkey, m_keys[i]);
            step("t4b");
        end
        next_rkey = 1'b0;
        step("t4w");
        check_eq("t4_vld_off", KW'(rkey_vld), KW'(0));
        check_eq("t4_rkey_zero", rkey, KW'(0));

        // Load request while busy in an AES-256 block
        pulse_load(2'd2);
        load_keys(15, 1'b0, nw);
        next_rkey = 1'b1;
        for (int i = 0; i < 4; i++) step("t5a");
        next_rkey = 1'b0;
        key_load = 1'b1; klen_in = 2'd0;
        step("t5l");
        key_load = 1'b0;
        next_rkey = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            check_eq("t5_seq", rkey, m_keys[i]);
            step("t5b");
        end
        next_rkey = 1'b0;
        check_eq("t5_klen_hold", KW'(klen_sel), KW'(2));
        step("t5w");
        check_eq("t5_rdy", KW'(rk_in_rdy), KW'(1));
        check_eq("t5_klen", KW'(klen_sel), KW'(0));

        // Asynchronous reset in the middle of a load
        rk_in_vld = 1'b1;
        for (int i = 0; i < 3; i++) step("t6ld");
        rk_in_vld = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("t6_rdy", KW'(rk_in_rdy), KW'(0));
        check_eq("t6_vld", KW'(rkey_vld), KW'(0));
        check_eq("t6_busy", KW'(busy), KW'(0));
        check_eq("t6_err", KW'(cfg_err), KW'(0));
        check_eq("t6_klen", KW'(klen_sel), KW'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 4; i++) step("t6idle");

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            key_load  = ($urandom_range(0, 39) == 0);
            key_flush = ($urandom_range(0, 59) == 0);
            klen_in   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rk_in_vld = ($urandom_range(0, 9) < 7);
            rk_in     = {$urandom, $urandom, $urandom, $urandom};
            next_rkey = ($urandom_range(0, 9) < 6);
            step("rnd");
        end
        idle_inputs();
        step("end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dec_rkey_sequencer.md
Name: dec_rkey_sequencer

Overview:
Round-key store and sequencer for the AES decryption engine. The host loads a fully expanded key schedule in forward order (round 0..Nr). The block then serves the keys in reverse order (Nr..0) over the engine's rkey/rkey_vld/next_rkey handshake, wrapping automatically for every ciphertext block. It also drives the engine's klen_sel so the key length always matches the stored schedule, and makes key changes safe at block boundaries only.

Parameters:
KEY_W, 128, round-key width in bits.
MAX_RK, 15, round-key slots (covers AES-256, Nr=14).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
key_load  in  1  one-cycle pulse: start loading a new schedule with length klen_in.
klen_in  in  2  00=128, 01=192, 10=256, 11=invalid; sampled on key_load.
key_flush  in  1  one-cycle pulse: invalidate the stored schedule.
rk_in  in  KEY_W  round-key write data, forward order.
rk_in_vld  in  1  rk_in valid.
rk_in_rdy  out  1  ready to accept rk_in.
rkey  out  KEY_W  current round key to the engine.
rkey_vld  out  1  rkey valid.
next_rkey  in  1  engine consumes the current rkey.
klen_sel  out  2  latched key length to the engine.
busy  out  1  mid-block: rptr != Nr.
cfg_err  out  1  sticky; set on key_load with klen_in=11.

Behaviour:
- Reset (async, rst=0):
  - state=EMPTY, wptr=0, rptr=0.
  - klen_sel=00, rkey_vld=0, rk_in_rdy=0, busy=0, cfg_err=0.
  - Key slots are not reset.
- Nr = 10/12/14 for klen 00/01/10, derived from the latched klen_sel.
- rkey = slot[rptr], combinational (zero latency), forced to 0 when rkey_vld=0.
- EMPTY:
  - rk_in_rdy=0, rkey_vld=0.
  - key_load with valid klen_in: latch klen_sel, wptr=0, cfg_err=0, go to LOAD.
  - key_load with klen_in=11: set cfg_err=1, stay in EMPTY.
- LOAD:
  - rk_in_rdy=1.
  - Each cycle with rk_in_vld=1 writes slot[wptr] and increments wptr.
  - Write at wptr==Nr: go to SERVE next cycle with rptr=Nr and rk_in_rdy=0. Exactly Nr+1 beats are accepted.
  - key_flush: go to EMPTY. A new key_load restarts LOAD with wptr=0.
- SERVE:
  - rkey_vld=1.
  - Each cycle with next_rkey=1: rptr <= (rptr==0) ? Nr : rptr-1. The wrap is seamless; back-to-back blocks need no idle cycle.
  - next_rkey while rkey_vld=0 is ignored.
- key_load or key_flush in SERVE:
  - When busy=0 and next_rkey=0 in that cycle: act immediately (flush goes to EMPTY; load goes to LOAD or sets cfg_err as in EMPTY).
  - Otherwise: record as pending (klen_in captured with a pending load), keep serving. Execute on the first cycle with rptr==Nr and next_rkey=0, i.e. at the block boundary after the wrap.
  - A later request overwrites the pending one. key_flush wins over key_load in the same cycle.
- Invalid klen in a pending load: cfg_err=1, state goes to EMPTY.
- busy is combinational: (state==SERVE) && (rptr != Nr).
- The engine consumes Nr+1 keys per block: one at ciphertext load, Nr in rounds.

Decomposition:
- Shared package aes_dec_pkg:
  - klen_t enum (KLEN128, KLEN192, KLEN256, KLEN_INV).
  - NR_128=10, NR_192=12, NR_256=14.
  - function klen_to_nr.
  - seq_state_t enum (EMPTY, LOAD, SERVE).
- Sub-module rk_regfile: MAX_RK x KEY_W storage, one synchronous write port, one asynchronous read port. The FSM and pointers stay in the top.

Test Plan:
1. AES-128 load K_i={16{i[7:0]}}, i=0..10, no gaps -> rk_in_rdy drops after the 11th beat; next cycle rkey_vld=1, rkey=K10, klen_sel=00. Eleven next_rkey pulses show K10..K0, then rkey=K10 again with busy=0.
2. AES-256 load of 15 keys with rk_in_vld gaps every other cycle -> exactly 15 writes. rkey sequence K14..K0, klen_sel=10. next_rkey held high for 30 cycles -> two full sequences with no bubble.
3. key_load with klen_in=11 from EMPTY -> cfg_err=1, rk_in_rdy=0, rkey_vld=0. A subsequent valid key_load clears cfg_err.
4. AES-192 serving; key_flush after 5 next_rkey pulses -> rkey_vld stays 1 and serves K7..K0. After the wrap (rptr=12, next_rkey=0) the next edge gives rkey_vld=0, rkey=0.
5. key_load(klen=00) while busy in an AES-256 block -> current block completes through K0. At the boundary: LOAD, rk_in_rdy=1, klen_sel=00.
6. rst=0 asserted mid-LOAD between clock edges -> all outputs return to reset values immediately, without a clock edge. After release, the block stays in EMPTY.
